// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one binary-to-BCD converter among N clients.
// Optional watchdog with err output: define BCDARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
    parameter int N   = 4,
    parameter int W   = 18,
    parameter int BW  = 4 * ((W + 2) / 3),
    parameter int TMO = 64,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  bin_in,
    output logic [N-1:0]    ack,
    output logic [BW-1:0]   bcd_out,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
`ifdef BCDARB_TIMEOUT_EN
    output logic            err,
`endif
    output logic            conv_start,
    output logic [W-1:0]    conv_binary,
    input  logic            conv_done,
    input  logic [BW-1:0]   conv_bcd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_RESP
    } state_t;

    localparam logic [IW:0]   NL   = (IW + 1)'(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (N < 2 || N > 8 || TMO <= 2 * W + 4) begin : g_param_chk
        $error("bcd_conv_arbiter: parameter out of range");
    end

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gid;
    logic [W-1:0]    r_bin;
    logic [BW-1:0]   r_bcd;
    logic            w_found;
    logic [IW-1:0]   w_pick;
    logic [IW:0]     w_sum;

`ifdef BCDARB_TIMEOUT_EN
    localparam int            CW   = $clog2(TMO + 1);
    localparam logic [CW-1:0] TLIM = CW'(TMO - 1);

    logic [CW-1:0]   r_wdog;
    logic            r_tmo;
    logic            w_wd_hit;

    assign w_wd_hit = (r_wdog == TLIM);
`endif

    // Scan downward so the lowest offset from the pointer wins last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IW + 1)'(k);
            if (w_sum >= NL) begin
                w_sum = w_sum - NL;
            end
            if (req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (conv_done) begin
                    w_next = S_RELEASE;
                end
`ifdef BCDARB_TIMEOUT_EN
                else if (w_wd_hit) begin
                    w_next = S_RELEASE;
                end
`endif
            end
            S_RELEASE: begin
                if (!conv_done) begin
                    w_next = S_RESP;
                end
`ifdef BCDARB_TIMEOUT_EN
                else if (w_wd_hit) begin
                    w_next = S_RESP;
                end
`endif
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
            r_gid <= '0;
            r_bin <= '0;
            r_bcd <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gid <= w_pick;
                        r_bin <= bin_in[w_pick*W +: W];
                    end
                end
                S_ISSUE: begin
                    if (conv_done) begin
                        r_bcd <= conv_bcd;
                    end
`ifdef BCDARB_TIMEOUT_EN
                    else if (w_wd_hit) begin
                        r_bcd <= '0;
                    end
`endif
                end
                S_RESP: begin
                    r_ptr <= (r_gid == LAST) ? '0 : r_gid + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BCDARB_TIMEOUT_EN
    // Counter restarts on entry to ISSUE and again on entry to RELEASE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog <= '0;
            r_tmo  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (w_found) begin
                        r_tmo <= 1'b0;
                    end
                end
                S_ISSUE, S_RELEASE: begin
                    if (w_next != r_state) begin
                        r_wdog <= '0;
                        if (w_wd_hit && (r_state == S_ISSUE ? !conv_done : conv_done)) begin
                            r_tmo <= 1'b1;
                        end
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_wdog <= '0;
                end
            endcase
        end
    end

    assign err = (r_state == S_RESP) && r_tmo;
`endif

    assign busy        = (r_state != S_IDLE);
    assign conv_start  = (r_state == S_ISSUE);
    assign conv_binary = r_bin;
    assign bcd_out     = r_bcd;
    assign grant_id    = r_gid;
    assign ack         = (r_state == S_RESP) ? (N'(1) << r_gid) : '0;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a converter stub and a
// round-robin/BCD reference model checked on every acknowledge.
module tb_bcd_conv_arbiter;

    localparam int N  = 4;
    localparam int W  = 18;
    localparam int BW = 24;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  bin_in = '0;
    logic [N-1:0]    ack;
    logic [BW-1:0]   bcd_out;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            conv_start;
    logic [W-1:0]    conv_binary;
    logic            conv_done;
    logic [BW-1:0]   conv_bcd;
`ifdef BCDARB_TIMEOUT_EN
    logic            err;
`endif

    bcd_conv_arbiter #(.N(N), .W(W)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .bin_in(bin_in),
        .ack(ack),
        .bcd_out(bcd_out),
        .grant_id(grant_id),
        .busy(busy),
`ifdef BCDARB_TIMEOUT_EN
        .err(err),
`endif
        .conv_start(conv_start),
        .conv_binary(conv_binary),
        .conv_done(conv_done),
        .conv_bcd(conv_bcd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int d = 0; d < BW / 4; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Converter stub: done 2W cycles after start, held until start drops.
    logic stub_run = 1'b0;
    logic stub_done = 1'b0;
    logic stub_dead = 1'b0;
    logic force_done = 1'b0;
    int   stub_cnt = 0;
    logic [BW-1:0] stub_bcd = '0;

    always @(posedge clk) begin
        if (!rst) begin
            stub_run  <= 1'b0;
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_bcd  <= '0;
        end else if (!stub_run && !stub_done && conv_start && !stub_dead) begin
            stub_run <= 1'b1;
            stub_cnt <= 2 * W;
        end else if (stub_run) begin
            if (stub_cnt == 1) begin
                stub_run  <= 1'b0;
                stub_done <= 1'b1;
                stub_bcd  <= to_bcd(32'(conv_binary));
            end
            stub_cnt <= stub_cnt - 1;
        end else if (stub_done && !conv_start) begin
            stub_done <= 1'b0;
        end
    end

    assign conv_done = stub_done | force_done;
    assign conv_bcd  = stub_bcd;

    // Reference model: pending set, operands, round-robin pointer.
    logic        m_pend [N];
    int unsigned m_op   [N];
    int          m_ptr = 0;
    logic        m_tmo = 1'b0;
    int          cyc = 0;
    int          last_ack = -100;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_op[i]   = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            int w;
            cyc++;
`ifdef BCDARB_TIMEOUT_EN
            chk("err_level", 64'(err), 64'((ack != 0) && m_tmo));
`endif
            if (ack != 0) begin
                w = -1;
                for (int k = N - 1; k >= 0; k--) begin
                    if (m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                if (w < 0) begin
                    chk("spurious_ack", 64'(ack), 64'(0));
                end else begin
                    chk("model_ack", 64'(ack), 64'(1) << w);
                    chk("model_gid", 64'(grant_id), 64'(w));
                    chk("model_bin", 64'(conv_binary), 64'(m_op[w]));
                    chk("model_bcd", 64'(bcd_out),
                        m_tmo ? 64'(0) : 64'(to_bcd(m_op[w])));
                    chk("ack_gap_ge4", 64'(cyc - last_ack >= 4), 64'(1));
                    m_pend[w] = 1'b0;
                    m_ptr = (w + 1) % N;
                end
                last_ack = cyc;
            end
        end
    end

    task automatic raise(input int i, input int unsigned v);
        req[i] = 1'b1;
        bin_in[i*W +: W] = W'(v);
        m_op[i] = v;
        m_pend[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b1;
        #2;
    endtask

    // Returns at negedge+2 of the ack cycle; id=-1 on expiry.
    task automatic wait_ack(output int id, output int lat);
        id = -1;
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            #2;
            if (ack != 0) begin
                lat = n - 1;
                for (int i = 0; i < N; i++) if (ack[i]) id = i;
                return;
            end
        end
        chk("ack_timeout", 64'(1), 64'(0));
    endtask

    int id;
    int lat;
    int order [8];

    initial begin
        do_reset();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_bcd", 64'(bcd_out), 64'(0));
        chk("rst_gid", 64'(grant_id), 64'(0));
        chk("rst_start", 64'(conv_start), 64'(0));
        chk("rst_bin", 64'(conv_binary), 64'(0));

        raise(0, 7);
        raise(1, 99);
        wait_ack(id, lat);
        chk("sim_ack0", 64'(ack), 64'h1);
        chk("sim_bcd0", 64'(bcd_out), 64'h000007);
        req[0] = 1'b0;
        wait_ack(id, lat);
        chk("sim_ack1", 64'(ack), 64'h2);
        chk("sim_bcd1", 64'(bcd_out), 64'h000099);
        req[1] = 1'b0;

        repeat (3) @(negedge clk);
        #2;
        raise(2, 12345);
        wait_ack(id, lat);
        chk("single_ack", 64'(ack), 64'h4);
        chk("single_bcd", 64'(bcd_out), 64'h012345);
        chk("single_gid", 64'(grant_id), 64'd2);
        chk("single_bin", 64'(conv_binary), 64'd12345);
        chk("single_lat", 64'(lat >= 2 * W + 3 && lat <= 2 * W + 5), 64'(1));
        req[2] = 1'b0;

        // Pointer is now 3: requester 3 is granted first, then reset.
        repeat (2) @(negedge clk);
        #2;
        raise(1, 500);
        raise(3, 262143);
        for (int n = 0; n < 10 && !conv_start; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("pre_rst_gid", 64'(grant_id), 64'd3);
        do_reset();
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_start", 64'(conv_start), 64'(0));
        chk("mrst_ack", 64'(ack), 64'(0));
        chk("mrst_bcd", 64'(bcd_out), 64'(0));
        wait_ack(id, lat);
        chk("mrst_first", 64'(ack), 64'h2);
        chk("mrst_bcd1", 64'(bcd_out), 64'h000500);
        req[1] = 1'b0;
        wait_ack(id, lat);
        chk("max_ack", 64'(ack), 64'h8);
        chk("max_bcd", 64'(bcd_out), 64'h262143);
        req[3] = 1'b0;

        repeat (2) @(negedge clk);
        #2;
        raise(0, 0);
        wait_ack(id, lat);
        chk("zero_bcd", 64'(bcd_out), 64'h000000);
        req[0] = 1'b0;

        // Drop request and change operand mid-service.
        repeat (2) @(negedge clk);
        #2;
        raise(2, 4321);
        repeat (5) @(negedge clk);
        req[2] = 1'b0;
        bin_in[2*W +: W] = W'(999);
        wait_ack(id, lat);
        chk("drop_ack", 64'(ack), 64'h4);
        chk("drop_bcd", 64'(bcd_out), 64'h004321);

        // Stale done while idle with no requests.
        repeat (2) @(negedge clk);
        force_done = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("stale_busy", 64'(busy), 64'(0));
        end
        force_done = 1'b0;
        repeat (2) @(negedge clk);

        do_reset();
        for (int i = 0; i < N; i++) raise(i, 100 + 11 * i);
        for (int t = 0; t < 8; t++) begin
            wait_ack(id, lat);
            order[t] = id;
            if (t < 7 && id >= 0) raise(id, 1000 * t + 3 * id);
        end
        req = '0;
        for (int t = 0; t < 8; t++) chk("rr_order", 64'(order[t]), 64'(t % 4));

`ifdef BCDARB_TIMEOUT_EN
        repeat (3) @(negedge clk);
        #2;
        stub_dead = 1'b1;
        m_tmo = 1'b1;
        raise(1, 777);
        wait_ack(id, lat);
        chk("tmo_ack", 64'(ack), 64'h2);
        chk("tmo_err", 64'(err), 64'(1));
        chk("tmo_bcd", 64'(bcd_out), 64'(0));
        req[1] = 1'b0;
        m_tmo = 1'b0;
        stub_dead = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        raise(1, 777);
        wait_ack(id, lat);
        chk("post_tmo_bcd", 64'(bcd_out), 64'h000777);
        req[1] = 1'b0;
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one double_dabble binary-to-BCD converter among N requesters.
- Latches the winning requester's operand and drives the converter's start/done handshake.
- Captures the BCD result and returns it with a one-cycle ack to the winner.
- Sits between client blocks (display drivers, UART formatters) and a single converter instance.

Parameters:
- N, 4, number of requesters (2..8).
- W, 18, binary operand width; must match the converter's W.
- BW, 4*ceil(W/3), BCD result width (24 at default).
- TMO, 64, watchdog limit in cycles. Used only with BCDARB_TIMEOUT_EN; must be > 2*W+4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- req  in  N  per-requester request level; hold high until own ack.
- bin_in  in  N*W  operands; requester i at bits [i*W +: W].
- ack  out  N  one-hot, one-cycle pulse; result for that requester valid on bcd_out.
- bcd_out  out  BW  registered result; holds value until next capture.
- grant_id  out  clog2(N)  index of requester currently or last served.
- busy  out  1  high in every state except IDLE.
- conv_start  out  1  to converter start.
- conv_binary  out  W  to converter binary; registered, stable for the whole transaction.
- conv_done  in  1  from converter done.
- conv_bcd  in  BW  from converter bcd.
- err  out  1  only with BCDARB_TIMEOUT_EN; pulses with ack on timeout.

Behaviour:
- Reset (rst=0 at clk edge), regardless of state:
  - state=IDLE; ack=0, bcd_out=0, grant_id=0, busy=0, conv_start=0, conv_binary=0, err=0.
  - RR pointer=0, so requester 0 has highest priority first.
- IDLE:
  - Find the first asserted req scanning from the pointer upward, wrapping modulo N.
  - If found: register grant_id=i and conv_binary=bin_in[i]; go to ISSUE.
  - No req: stay in IDLE.
- ISSUE:
  - conv_start=1.
  - On conv_done=1: capture bcd_out=conv_bcd, go to RELEASE.
- RELEASE:
  - conv_start=0.
  - Wait for conv_done=0 (converter back in INIT), then go to RESP.
  - If conv_done is already low, leave after 1 cycle.
- RESP:
  - ack[grant_id]=1 for exactly one cycle.
  - Pointer=(grant_id+1) mod N; go to IDLE.
- Latency: grant to ack = 3 cycles + converter time; with the current converter that is 2W+1 cycles from start. Minimum gap between consecutive acks: 4 cycles.
- Request rules:
  - Only req/bin_in at the IDLE decision cycle matter; bin_in changes after grant are ignored.
  - req dropped mid-service: service still completes and ack still pulses.
  - A requester must drop req in the cycle after its ack, or it is re-eligible (at lowest priority).
- Simultaneous requests: strict round-robin. With all N asserted continuously, service order is p, p+1, … wrapping; no starvation, each requester waits at most N-1 transactions.
- bcd_out changes only on capture; it stays valid after ack until the next transaction captures.
- conv_done high while in IDLE (stale converter) is ignored; arbitration proceeds normally.

Optional Feature:
- Macro: BCDARB_TIMEOUT_EN.
- Defined:
  - Watchdog counter cleared on entry to ISSUE, incremented each ISSUE cycle.
  - When the count reaches TMO with conv_done still 0: bcd_out=0, go to RELEASE.
  - The following RESP asserts err=1 together with ack; err is 0 on every other cycle.
  - If RELEASE sees conv_done stuck high, the watchdog also fires after TMO cycles and forces RESP.
- Undefined: no counter, no err port; ISSUE waits indefinitely.

Test Plan:
- Single request: req[2]=1, bin_in[2]=12345 → conv_binary=12345; ack=4'b0100 after 2W+4 cycles (±1); bcd_out=24'h012345; grant_id=2.
- Simultaneous: req=4'b0011 from reset, operands 7 and 99 → ack[0] with 24'h000007, then ack[1] with 24'h000099; acks ≥4 cycles apart.
- Round-robin fairness: req=4'b1111 held (each re-raised after ack) for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Boundary values:
  - bin_in=262143 → bcd_out=24'h262143.
  - bin_in=0 → bcd_out=24'h000000.
- Reset mid-operation: rst=0 for 1 cycle during ISSUE → next cycle busy=0, conv_start=0, ack=0, bcd_out=0; pending req re-served from requester 0 priority.
- Timeout (BCDARB_TIMEOUT_EN, TMO=64, converter stub never asserts done) → after 64 ISSUE cycles, ack[i] and err both pulse with bcd_out=0; next request still served.
